// File: rtl/uart_rx_ctrl.sv
// Frame-level UART receive controller: start detection, oversample/bit counting,
// shift-in, parity/stop checking. Optional input synchroniser via UART_RX_IN_SYNC_EN.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            prescale,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [4:0]            edge_count,
  output logic [4:0]            presc_q,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
`ifdef UART_RX_IN_SYNC_EN
  ,
  output logic                  rx_sync
`endif
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_line;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q, par_typ_q, frame_bad;
  logic                  bit_end, par_exp;
  logic                  start_frame, go_data, shift_en, set_bad, load_pd;
  logic                  valid_d, par_err_d, stp_err_d, glitch_d;

`ifdef UART_RX_IN_SYNC_EN
  logic sync1, sync2;

  // Idle-high line: both stages reset to 1 so reset release never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      sync2 <= sync1;
    end
  end

  assign rx_line = sync2;
  assign rx_sync = sync2;
`else
  assign rx_line = RX_IN;
`endif

  assign busy        = (state_q != IDLE);
  assign dat_samp_en = busy;
  assign bit_end     = busy && (edge_count == (presc_q - 5'd1));
  assign par_exp     = (^shift_reg) ^ par_typ_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    go_data     = 1'b0;
    shift_en    = 1'b0;
    set_bad     = 1'b0;
    load_pd     = 1'b0;
    valid_d     = 1'b0;
    par_err_d   = 1'b0;
    stp_err_d   = 1'b0;
    glitch_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_line) begin
          state_d     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          if (!sampled_bit) begin
            state_d = DATA;
            go_data = 1'b1;
          end else begin
            state_d  = IDLE;
            glitch_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          if (sampled_bit != par_exp) begin
            par_err_d = 1'b1;
            set_bad   = 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
          end else if (!frame_bad) begin
            valid_d = 1'b1;
            load_pd = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_count  <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      P_DATA      <= '0;
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      frame_bad   <= 1'b0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= valid_d;
      par_err     <= par_err_d;
      stp_err     <= stp_err_d;
      strt_glitch <= glitch_d;

      if (!busy || bit_end) edge_count <= '0;
      else                  edge_count <= edge_count + 5'd1;

      // Frame configuration is frozen at the start edge; only 8 and 16 are legal ratios.
      if (start_frame) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        presc_q   <= (prescale == 5'd16) ? 5'd16 : 5'd8;
        frame_bad <= 1'b0;
      end else if (set_bad) begin
        frame_bad <= 1'b1;
      end

      if (go_data)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
      if (load_pd)  P_DATA    <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of frames plus hand-written
// glitch, back-to-back and mid-frame reset sequences, strobes checked via an expected queue.
module tb_uart_rx_ctrl;

  localparam logic [1:0] EV_VALID  = 2'd0;
  localparam logic [1:0] EV_PAR    = 2'd1;
  localparam logic [1:0] EV_STP    = 2'd2;
  localparam logic [1:0] EV_GLITCH = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [4:0] prescale;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [4:0] edge_count;
  logic [4:0] presc_q;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, strt_glitch, busy;
`ifdef UART_RX_IN_SYNC_EN
  logic       rx_sync;
`endif

  int total = 0;
  int bad = 0;
  int busy_total = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [4:0] presc;
    int         bit_cyc;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_par;
    logic       exp_stp;
    logic [7:0] exp_pdata;
    int         exp_busy;
  } vec_t;

  vec_t vecs[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Sampler stand-in: the bench holds each bit across the sample point, so the line value is the vote.
`ifdef UART_RX_IN_SYNC_EN
  assign sampled_bit = rx_sync;
`else
  assign sampled_bit = rx_in;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK         (clk),
    .RST         (rst),
    .RX_IN       (rx_in),
    .PAR_EN      (par_en),
    .PAR_TYP     (par_typ),
    .prescale    (prescale),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_count  (edge_count),
    .presc_q     (presc_q),
    .P_DATA      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch),
    .busy        (busy)
`ifdef UART_RX_IN_SYNC_EN
    ,
    .rx_sync     (rx_sync)
`endif
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_ev(input logic [1:0] kind, input string nm);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected strobe, P_DATA=%0h at %0t", nm, p_data, $time);
    end else begin
      e = exp_q.pop_front();
      chk(nm, {22'd0, kind, p_data}, {22'd0, e});
    end
  endtask

  always @(posedge clk) begin
    int n;
    #1;
    if (busy) busy_total++;
    n = int'(data_valid) + int'(par_err) + int'(stp_err) + int'(strt_glitch);
    if (n > 0) chk("single_strobe", n, 1);
    if (data_valid)  check_ev(EV_VALID,  "data_valid");
    if (par_err)     check_ev(EV_PAR,    "par_err");
    if (stp_err)     check_ev(EV_STP,    "stp_err");
    if (strt_glitch) check_ev(EV_GLITCH, "strt_glitch");
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input logic v, input int n);
    @(negedge clk);
    rx_in = v;
    repeat (n) @(posedge clk);
  endtask

  function automatic vec_t mk(input logic [4:0] presc, input int bc, input logic pe, input logic pt,
                              input logic [7:0] d, input logic pb, input logic sb,
                              input logic ev, input logic ep, input logic es,
                              input logic [7:0] epd, input int eb);
    vec_t v;
    v.presc = presc; v.bit_cyc = bc; v.par_en = pe; v.par_typ = pt; v.data = d;
    v.par_bit = pb; v.stop_bit = sb; v.exp_valid = ev; v.exp_par = ep; v.exp_stp = es;
    v.exp_pdata = epd; v.exp_busy = eb;
    return v;
  endfunction

  // Start bit is seen on bit_cyc+1 edges (detection edge plus one full bit); every later bit on bit_cyc edges.
  task automatic drive_frame(input vec_t v, input int idle);
    int b0;
    @(negedge clk);
    prescale = v.presc;
    par_en   = v.par_en;
    par_typ  = v.par_typ;
    rx_in    = 1'b0;
    b0 = busy_total;
    if (v.exp_par)   exp_q.push_back({EV_PAR,   v.exp_pdata});
    if (v.exp_stp)   exp_q.push_back({EV_STP,   v.exp_pdata});
    if (v.exp_valid) exp_q.push_back({EV_VALID, v.exp_pdata});
    repeat (2) @(posedge clk);
    #1;
    chk("presc_q", {27'd0, presc_q}, v.bit_cyc);
    chk("dat_samp_en", {31'd0, dat_samp_en}, 1);
    chk("edge_count_start", {27'd0, edge_count}, 1);
    repeat (v.bit_cyc - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(v.data[i], v.bit_cyc);
    if (v.par_en) send_bit(v.par_bit, v.bit_cyc);
    send_bit(v.stop_bit, v.bit_cyc);
    if (idle > 0) begin
      @(negedge clk);
      rx_in = 1'b1;
      repeat (idle) @(posedge clk);
      @(negedge clk);
      chk("busy_cycles", busy_total - b0, v.exp_busy);
      chk("events_drained", exp_q.size(), 0);
      chk("p_data_end", {24'd0, p_data}, {24'd0, v.exp_pdata});
      chk("idle_busy", {31'd0, busy}, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_samp_en"}, {31'd0, dat_samp_en}, 0);
    chk({tag, "_edge"}, {27'd0, edge_count}, 0);
    chk({tag, "_presc_q"}, {27'd0, presc_q}, 0);
    chk({tag, "_p_data"}, {24'd0, p_data}, 0);
    chk({tag, "_strobes"}, {28'd0, data_valid, par_err, stp_err, strt_glitch}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b0;
    vec_t v;
    logic [7:0] abort_byte;

    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0; prescale = 5'd8;

    //               presc  bc  pe  pt  data   pb  sb  val par stp  pdata  busy
    vecs[0] = mk(5'd8,   8, 0, 0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5,  80);
    vecs[1] = mk(5'd16, 16, 1, 0, 8'h3C, 0, 1, 1, 0, 0, 8'h3C, 176);
    vecs[2] = mk(5'd16, 16, 1, 0, 8'h3C, 1, 1, 0, 1, 0, 8'h3C, 176);
    vecs[3] = mk(5'd8,   8, 0, 0, 8'h55, 0, 0, 0, 0, 1, 8'h3C,  80);
    vecs[4] = mk(5'd8,   8, 1, 1, 8'h07, 0, 1, 1, 0, 0, 8'h07,  88);
    vecs[5] = mk(5'd5,   8, 0, 0, 8'hC3, 0, 1, 1, 0, 0, 8'hC3,  80);
    vecs[6] = mk(5'd8,   8, 1, 0, 8'h01, 0, 0, 0, 1, 1, 8'hC3,  88);
    vecs[7] = mk(5'd31,  8, 1, 1, 8'hFF, 1, 1, 1, 0, 0, 8'hFF,  88);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 8; i++) drive_frame(vecs[i], 3);

    // Short low pulse: start bit fails its mid-bit vote.
    @(negedge clk);
    prescale = 5'd8;
    rx_in = 1'b0;
    b0 = busy_total;
    exp_q.push_back({EV_GLITCH, 8'hFF});
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_edge_count", {27'd0, edge_count}, 1);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_cycles", busy_total - b0, 8);
    chk("glitch_events", exp_q.size(), 0);
    chk("glitch_p_data", {24'd0, p_data}, 8'hFF);

    // Back-to-back frames; prescale/parity inputs change mid-frame and must not disturb it.
    drive_frame(mk(5'd8, 8, 0, 0, 8'h01, 0, 1, 1, 0, 0, 8'h01, 80), 0);
    fork
      drive_frame(mk(5'd8, 8, 0, 0, 8'hFE, 0, 1, 1, 0, 0, 8'hFE, 80), 3);
      begin
        repeat (40) @(negedge clk);
        prescale = 5'd16;
        par_en = 1'b1;
        par_typ = 1'b1;
      end
    join
    drive_frame(mk(5'd16, 16, 0, 0, 8'h5A, 0, 1, 1, 0, 0, 8'h5A, 160), 3);

    // Reset in the middle of data bit 4.
    abort_byte = 8'h6B;
    @(negedge clk);
    prescale = 5'd8;
    par_en = 1'b0;
    rx_in = 1'b0;
    repeat (9) @(posedge clk);
    for (int i = 0; i < 4; i++) send_bit(abort_byte[i], 8);
    @(negedge clk);
    rx_in = abort_byte[4];
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    v = mk(5'd8, 8, 0, 0, 8'h81, 0, 1, 1, 0, 0, 8'h81, 80);
    drive_frame(v, 3);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-level controller for the UART receiver. Detects the start bit, runs the oversampling edge and bit counters, and enables the majority-vote sampler (data_sampling) during each bit. It also shifts in sampled bits, checks parity and stop, and presents a parallel byte with a one-cycle valid strobe. Sits between the RX_IN pin and the receiver's consumer, and owns sequencing of the sampler.

Parameters:
DATA_WIDTH, 8, data bits per frame (LSB first).

Ports:
CLK  input  1  system clock; all state on rising edge.
RST  input  1  reset, asynchronous, active-high.
RX_IN  input  1  serial line, idle high.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even, 1 = odd parity.
prescale  input  5  oversampling ratio; legal values 8 and 16.
sampled_bit  input  1  majority-vote result from sampler.
dat_samp_en  output  1  enables the sampler.
edge_count  output  5  current oversample edge index within the bit.
presc_q  output  5  latched, legalised prescale driven to the sampler.
P_DATA  output  DATA_WIDTH  received byte.
data_valid  output  1  one-cycle strobe: P_DATA holds a new good frame.
par_err  output  1  one-cycle strobe: parity mismatch.
stp_err  output  1  one-cycle strobe: stop bit sampled low.
strt_glitch  output  1  one-cycle strobe: start bit rejected.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST high, asynchronous): state IDLE; edge_count, bit counter, shift register, P_DATA, presc_q = 0. All strobes, dat_samp_en and busy = 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN==0 seen on a rising edge moves to START with edge_count=0.
  - The same edge latches PAR_EN and PAR_TYP, and latches prescale into presc_q. Any prescale value other than 8 or 16 is latched as 8.
  - Input changes during a frame have no effect.
- Non-IDLE states:
  - edge_count increments by 1 each cycle and wraps from presc_q-1 to 0. The wrap cycle (edge_count==presc_q-1) is the bit-end.
  - dat_samp_en = 1 in all non-IDLE states and 0 in IDLE.
- START: at bit-end, sampled_bit==0 moves to DATA with bit counter=0. Otherwise strt_glitch pulses and the state returns to IDLE.
- DATA: at each bit-end, sampled_bit shifts in LSB first and the bit counter increments. On bit-end with counter==DATA_WIDTH-1, go to PARITY if latched PAR_EN, else STOP.
- PARITY: expected bit = XOR of shift register XOR latched PAR_TYP. At bit-end, a mismatch with sampled_bit pulses par_err and sets an internal frame-bad flag. Either way, go to STOP.
- STOP: at bit-end the state returns to IDLE.
  - sampled_bit==0: stp_err pulses.
  - sampled_bit==1 and no frame-bad flag: P_DATA <= shift register and data_valid pulses for one cycle.
  - P_DATA changes only on good frames.
- Latency: data_valid asserts at the last cycle of the stop bit plus one register stage. It is the cycle after the STOP bit-end edge.
- Back-to-back frames: RX_IN low on the first IDLE cycle after STOP is a new start. This gives a one-cycle resync gap per frame.
- The frame-bad flag clears on entry to START.
- Strobes are never asserted together except par_err followed by stp_err in consecutive bit periods.
- RST asserted mid-frame aborts immediately with no strobes; RX_IN low after release starts a fresh frame.
- Bit counter width is clog2(DATA_WIDTH); edge_count is 5 bits; no arithmetic overflow is possible for legal prescale.

Optional Feature:
- Macro UART_RX_IN_SYNC_EN.
- When defined: RX_IN passes through a 2-flop synchronizer (reset to 1) before start detection and the sampler tap, which is exported as an extra output rx_sync. Start detection and all strobes shift 2 cycles later relative to the pin.
- When undefined: RX_IN is used directly, no rx_sync port, and no added latency.

Test Plan:
- prescale=8, PAR_EN=0, frame 0xA5 with stop=1 -> data_valid pulses once, P_DATA=0xA5, no errors, busy high for 80 cycles.
- prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity 0 -> P_DATA=0x3C, data_valid=1. Repeat with parity 1 -> par_err pulse, no data_valid, P_DATA still 0x3C.
- RX_IN low for only 2 cycles at prescale=8 (sampled_bit=1 at start bit-end) -> strt_glitch pulse, return to IDLE, no DATA entry.
- Byte 0x55 with stop bit 0 -> stp_err pulse, data_valid 0, P_DATA unchanged.
- Two back-to-back frames 0x01 then 0xFE, and prescale changed to 16 mid-frame -> both bytes received in order at prescale 8; the new prescale applies only to the next frame.
- RST pulsed during DATA bit 4 -> all outputs 0 asynchronously; a following clean frame 0x81 is received correctly.
